// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target register responder.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK,
    IGNORE
  } state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [6:0] DEF_DEV_ADDR = 7'h48;

endpackage

// File: rtl/i2c_target_filter.sv
// Two-flop synchronizer plus a FILT_LEN-sample glitch filter on one I2C line.
// o_rise/o_fall pulse for one cycle together with the change of o_level.
module i2c_target_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;

  // The level only flips after FILT_LEN consecutive samples disagree with it;
  // any agreeing sample restarts the count, so short glitches are dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_d};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_sync[1] != r_level) begin
        if (r_cnt == LAST) begin
          r_level <= r_sync[1];
          r_cnt   <= '0;
          r_rise  <= r_sync[1];
          r_fall  <= ~r_sync[1];
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register file: pointer write, burst write,
// burst read with auto-increment, plus a local fabric write port.
module i2c_target_regs
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
  parameter int         NREGS    = 16,
  parameter int         FILT_LEN = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       scl_i,
  input  logic                       sda_i,
  output logic                       sda_oe_o,
  input  logic                       loc_we_i,
  input  logic [$clog2(NREGS)-1:0]   loc_idx_i,
  input  logic [7:0]                 loc_wdata_i,
  output logic [NREGS*8-1:0]         regs_o,
  output logic                       i2c_wr_o,
  output logic [$clog2(NREGS)-1:0]   i2c_idx_o,
  output logic                       busy_o
);

  localparam int IW = $clog2(NREGS);

  logic w_sclLvl, w_sclRise, w_sclFall;
  logic w_sdaLvl, w_sdaRise, w_sdaFall;
  logic w_start, w_stop;

  state_e        r_state, w_stateNext;
  logic [2:0]    r_bitCnt, w_bitCntNext;
  logic [7:0]    r_shift, w_shiftNext;
  logic [IW-1:0] r_ptr, w_ptrNext, w_ptrInc;
  logic          r_sdaOe, w_sdaOeNext;
  logic          r_busy, w_busyNext;
  logic          r_rw, w_rwNext;
  logic          r_mAck, w_mAckNext;
  logic          w_wr;
  logic [7:0]    w_byte;
  logic [7:0]    r_regs [NREGS];

  i2c_target_filter #(.FILT_LEN(FILT_LEN)) u_sclFilt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_d     (scl_i),
    .o_level (w_sclLvl),
    .o_rise  (w_sclRise),
    .o_fall  (w_sclFall)
  );

  i2c_target_filter #(.FILT_LEN(FILT_LEN)) u_sdaFilt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_d     (sda_i),
    .o_level (w_sdaLvl),
    .o_rise  (w_sdaRise),
    .o_fall  (w_sdaFall)
  );

  assign w_start  = w_sdaFall & w_sclLvl;
  assign w_stop   = w_sdaRise & w_sclLvl;
  assign w_byte   = {r_shift[6:0], w_sdaLvl};
  assign w_ptrInc = r_ptr + IW'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_ptr    <= '0;
      r_sdaOe  <= 1'b0;
      r_busy   <= 1'b0;
      r_rw     <= 1'b0;
      r_mAck   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_bitCnt <= w_bitCntNext;
      r_shift  <= w_shiftNext;
      r_ptr    <= w_ptrNext;
      r_sdaOe  <= w_sdaOeNext;
      r_busy   <= w_busyNext;
      r_rw     <= w_rwNext;
      r_mAck   <= w_mAckNext;
    end
  end

  // In the ACK states r_sdaOe doubles as the phase flag: low means waiting for
  // the 8th falling edge to pull SDA, high means waiting for the 9th to release.
  always_comb begin
    w_stateNext  = r_state;
    w_bitCntNext = r_bitCnt;
    w_shiftNext  = r_shift;
    w_ptrNext    = r_ptr;
    w_sdaOeNext  = r_sdaOe;
    w_busyNext   = r_busy;
    w_rwNext     = r_rw;
    w_mAckNext   = r_mAck;
    w_wr         = 1'b0;
    if (w_start) begin
      w_stateNext  = ADDR;
      w_busyNext   = 1'b1;
      w_bitCntNext = '0;
      w_sdaOeNext  = 1'b0;
      w_mAckNext   = 1'b0;
    end else if (w_stop) begin
      w_stateNext = IDLE;
      w_busyNext  = 1'b0;
      w_sdaOeNext = 1'b0;
      w_mAckNext  = 1'b0;
    end else begin
      case (r_state)
        ADDR: if (w_sclRise) begin
          w_shiftNext  = w_byte;
          w_bitCntNext = r_bitCnt + 3'd1;
          if (r_bitCnt == 3'd7) begin
            w_rwNext    = w_byte[0];
            w_stateNext = (w_byte[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
          end
        end
        ADDR_ACK: if (w_sclFall) begin
          if (!r_sdaOe) begin
            w_sdaOeNext = ~I2C_ACK;
          end else if (r_rw) begin
            w_shiftNext = r_regs[r_ptr];
            w_sdaOeNext = ~r_regs[r_ptr][7];
            w_stateNext = RDATA;
          end else begin
            w_sdaOeNext = 1'b0;
            w_stateNext = PTR;
          end
        end
        PTR: if (w_sclRise) begin
          w_shiftNext  = w_byte;
          w_bitCntNext = r_bitCnt + 3'd1;
          if (r_bitCnt == 3'd7) begin
            w_ptrNext   = w_byte[IW-1:0];
            w_stateNext = PTR_ACK;
          end
        end
        PTR_ACK: if (w_sclFall) begin
          if (!r_sdaOe) begin
            w_sdaOeNext = ~I2C_ACK;
          end else begin
            w_sdaOeNext = 1'b0;
            w_stateNext = WDATA;
          end
        end
        WDATA: if (w_sclRise) begin
          w_shiftNext  = w_byte;
          w_bitCntNext = r_bitCnt + 3'd1;
          if (r_bitCnt == 3'd7) begin
            w_wr        = 1'b1;
            w_stateNext = WDATA_ACK;
          end
        end
        WDATA_ACK: if (w_sclFall) begin
          if (!r_sdaOe) begin
            w_sdaOeNext = ~I2C_ACK;
          end else begin
            w_sdaOeNext = 1'b0;
            w_ptrNext   = w_ptrInc;
            w_stateNext = WDATA;
          end
        end
        RDATA: if (w_sclFall) begin
          if (r_bitCnt == 3'd7) begin
            w_sdaOeNext  = 1'b0;
            w_bitCntNext = '0;
            w_stateNext  = RACK;
          end else begin
            w_shiftNext  = {r_shift[6:0], r_shift[7]};
            w_sdaOeNext  = ~r_shift[6];
            w_bitCntNext = r_bitCnt + 3'd1;
          end
        end
        RACK: if (w_sclRise) begin
          if (w_sdaLvl == I2C_NACK) begin
            w_ptrNext   = w_ptrInc;
            w_stateNext = IGNORE;
          end else begin
            w_mAckNext = 1'b1;
          end
        end else if (w_sclFall && r_mAck) begin
          w_mAckNext  = 1'b0;
          w_ptrNext   = w_ptrInc;
          w_shiftNext = r_regs[w_ptrInc];
          w_sdaOeNext = ~r_regs[w_ptrInc][7];
          w_stateNext = RDATA;
        end
        default: ;
      endcase
    end
  end

  // The local write is applied after the I2C commit so it wins a same-index collision.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
    end else begin
      if (w_wr) r_regs[r_ptr] <= w_byte;
      if (loc_we_i) r_regs[loc_idx_i] <= loc_wdata_i;
    end
  end

  for (genvar k = 0; k < NREGS; k++) begin : g_flat
    assign regs_o[8*k +: 8] = r_regs[k];
  end

  assign sda_oe_o  = r_sdaOe;
  assign busy_o    = r_busy;
  assign i2c_wr_o  = w_wr;
  assign i2c_idx_o = r_ptr;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bit-banged I2C master driving i2c_target_regs, checked against a register/pointer model.
module tb_i2c_target_regs;

  localparam int NREGS = 16;
  localparam int Q     = 10;
  localparam int H     = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              scl_m = 1'b1;
  logic              sda_m = 1'b1;
  logic              loc_we = 1'b0;
  logic [3:0]        loc_idx = '0;
  logic [7:0]        loc_wdata = '0;
  logic              sda_oe_o;
  logic [NREGS*8-1:0] regs_o;
  logic              i2c_wr_o;
  logic [3:0]        i2c_idx_o;
  logic              busy_o;
  logic              sdaLine;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] mRegs [NREGS];
  int         mPtr = 0;
  logic [7:0] txData [8];
  int         wrLog [$];
  int         oeCount = 0;

  assign sdaLine = sda_m & ~sda_oe_o;

  i2c_target_regs dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .scl_i       (scl_m),
    .sda_i       (sdaLine),
    .sda_oe_o    (sda_oe_o),
    .loc_we_i    (loc_we),
    .loc_idx_i   (loc_idx),
    .loc_wdata_i (loc_wdata),
    .regs_o      (regs_o),
    .i2c_wr_o    (i2c_wr_o),
    .i2c_idx_o   (i2c_idx_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (i2c_wr_o) wrLog.push_back(int'(i2c_idx_o));
    if (sda_oe_o) oeCount++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkRegs(input string tag);
    logic [127:0] expV;
    for (int k = 0; k < NREGS; k++) expV[8*k +: 8] = mRegs[k];
    checkOutput(tag, regs_o, expV);
  endtask

  task automatic applyStimulus(input logic [3:0] idx, input logic [7:0] data);
    loc_we    = 1'b1;
    loc_idx   = idx;
    loc_wdata = data;
    tick(1);
    loc_we = 1'b0;
    mRegs[idx] = data;
  endtask

  task automatic writeBit(input logic b, input bit glitch);
    sda_m = b;
    tick(Q);
    scl_m = 1'b1;
    if (glitch) begin
      tick(8);
      scl_m = 1'b0;
      tick(2);
      scl_m = 1'b1;
      tick(10);
    end else begin
      tick(H);
    end
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic readBit(output logic b);
    sda_m = 1'b1;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    b = sdaLine;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic startCond();
    sda_m = 1'b1;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic stopCond();
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    sda_m = 1'b1;
    tick(H);
  endtask

  task automatic sendByte(input logic [7:0] d, input int glitchBit, output logic ack);
    for (int i = 7; i >= 0; i--) writeBit(d[i], i == glitchBit);
    readBit(ack);
  endtask

  task automatic recvByte(output logic [7:0] d, input logic ackBit);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      readBit(b);
      d = {d[6:0], b};
    end
    writeBit(ackBit, 1'b0);
  endtask

  task automatic setPtr(input logic [7:0] p, input string tag);
    logic ack;
    startCond();
    sendByte(8'h90, -1, ack);
    checkOutput({tag, "_addr_ack"}, ack, 1'b0);
    sendByte(p, -1, ack);
    checkOutput({tag, "_ptr_ack"}, ack, 1'b0);
    mPtr = int'(p) % NREGS;
  endtask

  task automatic i2cWrite(input logic [7:0] p, input int n, input string tag,
                          input int glitchByte, input int glitchBit);
    logic ack;
    setPtr(p, tag);
    checkOutput({tag, "_busy"}, busy_o, 1'b1);
    for (int i = 0; i < n; i++) begin
      sendByte(txData[i], (i == glitchByte) ? glitchBit : -1, ack);
      checkOutput($sformatf("%s_data%0d_ack", tag, i), ack, 1'b0);
      mRegs[mPtr] = txData[i];
      mPtr = (mPtr + 1) % NREGS;
    end
    stopCond();
    checkOutput({tag, "_idle"}, busy_o, 1'b0);
  endtask

  task automatic i2cRead(input int n, input string tag);
    logic       ack;
    logic [7:0] d;
    startCond();
    sendByte(8'h91, -1, ack);
    checkOutput({tag, "_raddr_ack"}, ack, 1'b0);
    for (int i = 0; i < n; i++) begin
      recvByte(d, (i == n - 1));
      checkOutput($sformatf("%s_byte%0d", tag, i), d, mRegs[mPtr]);
      mPtr = (mPtr + 1) % NREGS;
    end
    stopCond();
  endtask

  initial begin
    logic ack;
    bit   found;
    int   wrBase;
    int   oeBase;
    int   n;

    for (int k = 0; k < NREGS; k++) mRegs[k] = '0;

    // Reset state
    tick(3);
    checkOutput("rst_sda_oe", sda_oe_o, 1'b0);
    checkOutput("rst_busy", busy_o, 1'b0);
    checkOutput("rst_wr", i2c_wr_o, 1'b0);
    checkRegs("rst_regs");
    rst_n = 1'b1;
    tick(20);

    // Write burst to registers 3 and 4
    $display("[TB] write burst");
    wrBase = wrLog.size();
    txData[0] = 8'hA5;
    txData[1] = 8'h5A;
    i2cWrite(8'h03, 2, "burst", -1, -1);
    checkOutput("burst_wr_count", wrLog.size() - wrBase, 2);
    checkOutput("burst_wr_idx0", (wrLog.size() > wrBase) ? wrLog[wrBase] : -1, 3);
    checkOutput("burst_wr_idx1", (wrLog.size() > wrBase + 1) ? wrLog[wrBase + 1] : -1, 4);
    checkRegs("burst_regs");
    tick(20);

    // Read with repeated START, then a follow-up read proving the pointer landed on 5
    $display("[TB] read with repeated start");
    applyStimulus(4'd5, 8'hC3);
    setPtr(8'h03, "rdptr");
    i2cRead(2, "rdsr");
    tick(20);
    i2cRead(1, "rdnext");
    tick(20);

    // Wrong address: target must never pull SDA
    $display("[TB] wrong address");
    oeBase = oeCount;
    wrBase = wrLog.size();
    startCond();
    sendByte(8'hA0, -1, ack);
    checkOutput("waddr_nack", ack, 1'b1);
    sendByte(8'h55, -1, ack);
    checkOutput("waddr_nack2", ack, 1'b1);
    stopCond();
    checkOutput("waddr_oe_cycles", oeCount - oeBase, 0);
    checkOutput("waddr_no_wr", wrLog.size() - wrBase, 0);
    checkRegs("waddr_regs");
    tick(20);

    // Pointer wrap and pointer modulo
    $display("[TB] wrap-around");
    txData[0] = 8'h11;
    txData[1] = 8'h22;
    i2cWrite(8'h0F, 2, "wrap", -1, -1);
    checkOutput("wrap_reg15", regs_o[127:120], 8'h11);
    checkOutput("wrap_reg0", regs_o[7:0], 8'h22);
    tick(20);
    txData[0] = 8'h3C;
    i2cWrite(8'h13, 1, "ptrmod", -1, -1);
    checkOutput("ptrmod_reg3", regs_o[31:24], 8'h3C);
    checkRegs("ptrmod_regs");
    tick(20);

    // Local write colliding with an I2C commit to the same index
    $display("[TB] collision");
    txData[0] = 8'h5A;
    found = 1'b0;
    fork
      i2cWrite(8'h04, 1, "coll", -1, -1);
      begin
        for (int c = 0; c < 3000 && !found; c++) begin
          @(negedge clk);
          if (i2c_wr_o && i2c_idx_o == 4'd4) begin
            loc_we    = 1'b1;
            loc_idx   = 4'd4;
            loc_wdata = 8'h77;
            found     = 1'b1;
            @(negedge clk);
            loc_we = 1'b0;
          end
        end
      end
    join
    mRegs[4] = 8'h77;
    checkOutput("coll_commit_seen", found, 1'b1);
    checkOutput("coll_reg4", regs_o[39:32], 8'h77);
    checkRegs("coll_regs");
    tick(20);

    // Short SCL glitch inside a data bit
    $display("[TB] scl glitch");
    txData[0] = 8'h96;
    txData[1] = 8'h69;
    i2cWrite(8'h07, 2, "glitch", 0, 4);
    checkRegs("glitch_regs");
    tick(20);

    // Randomized write/read transactions
    $display("[TB] random transactions");
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) txData[i] = 8'($urandom);
      i2cWrite(8'($urandom_range(0, 255)), n, $sformatf("rndw%0d", it), -1, -1);
      checkRegs($sformatf("rndw%0d_regs", it));
      tick(20);
      setPtr(8'($urandom_range(0, 255)), $sformatf("rndp%0d", it));
      i2cRead($urandom_range(1, 3), $sformatf("rndr%0d", it));
      tick(20);
    end

    // Reset while the target is pulling SDA low during a read
    $display("[TB] reset mid-read");
    applyStimulus(4'd9, 8'h3C);
    setPtr(8'h09, "rstp");
    startCond();
    sendByte(8'h91, -1, ack);
    checkOutput("rstrd_addr_ack", ack, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 80 && !found; c++) begin
      if (sda_oe_o) found = 1'b1;
      else tick(1);
    end
    checkOutput("rstrd_driving", found, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rstrd_oe_released", sda_oe_o, 1'b0);
    checkOutput("rstrd_busy", busy_o, 1'b0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    tick(4);
    rst_n = 1'b1;
    tick(20);
    for (int k = 0; k < NREGS; k++) mRegs[k] = '0;
    mPtr = 0;
    i2cRead(1, "postrst");
    checkRegs("postrst_regs");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- I2C target (slave) responder with a byte-wide register file; the target-side counterpart of the SoC's I2C0 master.
- Instantiated in the FPGA top level on a board pin pair or an internal loopback net. Gives software a known device for I2C driver bring-up and lets local fabric logic exchange configuration bytes with the SoC.
- Oversamples SCL/SDA on the system clock. Open-drain SDA output only; the target never drives SCL and does no clock stretching.

Parameters:
- DEV_ADDR, 7'h48, 7-bit target address matched after START.
- NREGS, 16, number of 8-bit registers (power of two, 2..256).
- FILT_LEN, 4, consecutive equal samples required before a filtered SCL/SDA level changes.

Ports:
- clk_i  in  1  system clock, ≥20× SCL rate.
- rst_ni  in  1  synchronous active-low reset.
- scl_i  in  1  raw SCL pad input (asynchronous).
- sda_i  in  1  raw SDA pad input (asynchronous).
- sda_oe_o  out  1  1 = pull SDA low; 0 = release.
- loc_we_i  in  1  local write strobe.
- loc_idx_i  in  $clog2(NREGS)  local write register index.
- loc_wdata_i  in  8  local write data.
- regs_o  out  NREGS*8  flattened register file; register k is at [8k+7:8k].
- i2c_wr_o  out  1  one-cycle pulse per byte committed from I2C.
- i2c_idx_o  out  $clog2(NREGS)  index of that byte; valid while i2c_wr_o is high.
- busy_o  out  1  high between START and STOP.

Behaviour:
- Reset (rst_ni low at a clk_i edge): sda_oe_o=0, busy_o=0, i2c_wr_o=0, all registers 0, pointer 0, state IDLE, filters preset to 1.
- Input conditioning: 2-flop synchronizer, then a FILT_LEN glitch filter per line. An edge is a change of the filtered level. Edge-to-internal-event latency is 2+FILT_LEN cycles.
- START: filtered SDA falls while filtered SCL is high. Valid in any state, including repeated START. Sets busy_o, goes to ADDR, clears the bit counter, releases SDA.
- STOP: filtered SDA rises while filtered SCL is high. Any state goes to IDLE, busy_o=0, SDA released. Pointer is retained.
- Data sampling: SDA is sampled on filtered SCL rising edge, MSB first. Any SDA output change happens only on the cycle after a filtered SCL falling edge.
- States:
  - IDLE → ADDR on START.
  - ADDR: 8 bits received (7-bit address plus R/W). On match, go to ADDR_ACK. On mismatch, go to IGNORE, stay released, and wait for START/STOP.
  - ADDR_ACK: drive SDA low for the 9th clock.
    - R/W=0 → PTR.
    - R/W=1 → load the shift register from regs[ptr] → RDATA.
  - PTR: 8 bits received; ptr = byte mod NREGS → PTR_ACK (ACK) → WDATA.
  - WDATA: 8 bits received → commit regs[ptr] and pulse i2c_wr_o with i2c_idx_o=ptr, in the cycle of the 8th rising edge's event. Then WDATA_ACK (ACK); ptr increments, wrapping NREGS-1 → 0; → WDATA.
  - RDATA: sda_oe_o = ~bit for 8 bits → RACK. SDA is released for the 9th bit and the master's bit is sampled on the rising edge.
    - ACK (0): ptr increments with wrap, the next byte is loaded → RDATA.
    - NACK (1): ptr increments → IGNORE.
- ACK timing: asserted after the 8th SCL falling edge; released after the 9th falling edge.
- Local writes update the register in the same cycle they are presented. On a same-cycle, same-index collision with an I2C commit, the local write wins and i2c_wr_o still pulses.
- A read byte is captured at load time; later register changes do not affect a byte already in flight.
- Reset mid-transfer releases SDA immediately. The bus recovers at the next START.

Decomposition:
- Package i2c_target_pkg:
  - state enum {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE};
  - constants I2C_ACK=1'b0, I2C_NACK=1'b1;
  - the default target address.
- Sub-module i2c_target_filter: synchronizer, glitch filter, and rise/fall pulse outputs. Instantiated once for SCL and once for SDA.

Test Plan:
- Write burst: START, 0x90, 0x03, 0xA5, 0x5A, STOP → ACK on all 4 bytes; regs[3]=0xA5, regs[4]=0x5A; i2c_wr_o pulses twice with idx 3 then 4; busy_o low after STOP.
- Read with repeated START: set pointer 0x03, then Sr, 0x91, read 2 bytes (ACK, then NACK) → master sees 0xA5, 0x5A; ptr=5 afterwards.
- Wrong address: START, 0xA0 → no ACK (sda_oe_o stays 0 throughout); registers unchanged.
- Wrap-around: pointer 0x0F, write 0x11, 0x22 → regs[15]=0x11, regs[0]=0x22. Pointer byte 0x13 with NREGS=16 selects register 3.
- Collision and glitch: local write of 0x77 to idx 4 in the same cycle as an I2C commit of 0x5A to idx 4 → regs[4]=0x77. A 2-cycle SCL glitch during a data bit → no extra bit counted.
- Reset mid-read while driving SDA low → sda_oe_o=0 on the next clk_i edge; a subsequent START/0x91 read returns 0x00.
